// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - writer-priority, burst-limited arbiter sharing the frame SRAM port
// Optional ARB_FILL_GUARD_EN stalls reads of pixels the loader has not yet written this frame.
module sram_port_arbiter #(
  parameter int AW          = 20,
  parameter int DW          = 8,
  parameter int BURST_MAX   = 4,
  parameter int FRAME_WORDS = 72816
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_wdata,
  output logic          w_gnt,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  output logic [DW-1:0] r_rdata,
  output logic          r_rvalid,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic [AW:0]   wr_fill
);
  localparam logic [AW:0] FILL_MAX  = FRAME_WORDS[AW:0];
  localparam logic [AW:0] FILL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]  BURST_LIM = BURST_MAX[3:0];

  logic [3:0] burst_cnt;
  logic       rd_issued;
  logic       r_elig;
  logic       r_want;
  logic       burst_full;

`ifdef ARB_FILL_GUARD_EN
  // wr_fill is the next unwritten raster address, so anything below it is current-frame data
  assign r_elig = ({1'b0, r_addr} < wr_fill) || (wr_fill == FILL_MAX);
`else
  assign r_elig = 1'b1;
`endif

  assign r_want     = r_req && r_elig;
  assign burst_full = (burst_cnt == BURST_LIM);
  assign w_gnt      = !rst && w_req && !(r_want && burst_full);
  assign r_gnt      = !rst && r_want && (!w_req || burst_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else if (r_gnt || !r_req) begin
      burst_cnt <= 4'd0;
    end else if (w_gnt && r_want) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (w_gnt) begin
      sram_cen   <= 1'b0;
      sram_wen   <= 1'b0;
      sram_addr  <= w_addr;
      sram_wdata <= w_wdata;
    end else if (r_gnt) begin
      sram_cen   <= 1'b0;
      sram_wen   <= 1'b1;
      sram_addr  <= r_addr;
    end else begin
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_fill <= '0;
    end else if (frame_start) begin
      wr_fill <= w_gnt ? FILL_ONE : '0;
    end else if (w_gnt && (wr_fill != FILL_MAX)) begin
      wr_fill <= wr_fill + FILL_ONE;
    end
  end

  // Stage one marks the cycle the SRAM sees the read address; stage two presents the data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_issued <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      rd_issued <= r_gnt;
      r_rvalid  <= rd_issued;
      if (rd_issued) begin
        r_rdata <= sram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int FW    = 640;

`ifdef ARB_FILL_GUARD_EN
  localparam int EXP_FIRST_FILL = 151;
  localparam int EXP_GUARD_DATA = 8'hA7;
`else
  localparam int EXP_FIRST_FILL = 4;
  localparam int EXP_GUARD_DATA = 8'hAA;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_gnt;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_gnt;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic [AW:0]   wr_fill;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_gnt(w_gnt),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rdata(r_rdata), .r_rvalid(r_rvalid),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .wr_fill(wr_fill)
  );

  // SRAM macro: write on the edge, read data ready within the address cycle
  logic [DW-1:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) sram_mem[sram_addr[9:0]] <= sram_wdata;
  end
  assign sram_rdata = sram_mem[sram_addr[9:0]];

  typedef struct {int due; logic [DW-1:0] data;} rd_t;
  typedef struct packed {logic w; logic r; logic wg; logic rg; logic rv;} vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_burst, m_fill;
  logic m_cen, m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_mem [0:1023];
  rd_t rdq[$];
  logic obs_wg, obs_rg, obs_cen, obs_wen, obs_rv;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;
  int obs_fill;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // One clock: compare at negedge against the reference model, then advance it
  task automatic cycle();
    bit elig, rw, wg, rg, erv;
    @(negedge clk);
    elig = 1'b1;
`ifdef ARB_FILL_GUARD_EN
    elig = (int'(r_addr) < m_fill) || (m_fill == FW);
`endif
    rw = r_req && elig;
    wg = 1'b0;
    rg = 1'b0;
    if (!rst) begin
      if (w_req && rw) begin
        if (m_burst >= BURST) rg = 1'b1; else wg = 1'b1;
      end else begin
        wg = w_req;
        rg = rw;
      end
    end
    obs_wg = w_gnt; obs_rg = r_gnt; obs_cen = sram_cen; obs_wen = sram_wen;
    obs_addr = sram_addr; obs_rv = r_rvalid; obs_rdata = r_rdata; obs_fill = int'(wr_fill);
    chk("w_gnt", int'(w_gnt), int'(wg));
    chk("r_gnt", int'(r_gnt), int'(rg));
    chk("sram_cen", int'(sram_cen), int'(m_cen));
    chk("sram_wen", int'(sram_wen), int'(m_wen));
    chk("sram_addr", int'(sram_addr), int'(m_addr));
    chk("sram_wdata", int'(sram_wdata), int'(m_wdata));
    chk("wr_fill", obs_fill, m_fill);
    erv = (rdq.size() > 0) && (rdq[0].due == cyc);
    chk("r_rvalid", int'(r_rvalid), int'(erv));
    if (erv) begin
      chk("r_rdata", int'(r_rdata), int'(rdq[0].data));
      void'(rdq.pop_front());
    end
    if (rst) begin
      m_burst = 0; m_fill = 0; m_cen = 1'b1; m_wen = 1'b1; m_addr = '0; m_wdata = '0;
      rdq.delete();
    end else begin
      if (rg || !r_req) m_burst = 0;
      else if (wg && rw) m_burst++;
      if (frame_start) m_fill = wg ? 1 : 0;
      else if (wg && m_fill < FW) m_fill++;
      m_cen = !(wg || rg);
      m_wen = !wg;
      if (wg) begin
        m_addr = w_addr; m_wdata = w_wdata;
        m_mem[w_addr[9:0]] = w_wdata;
      end else if (rg) begin
        m_addr = r_addr;
        rdq.push_back('{cyc + 2, m_mem[r_addr[9:0]]});
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [0:20];
  int nw, first_fill, nrv, cap;
  bit got;

  initial begin
    tbl = '{5'b00000, 5'b10100, 5'b01010, 5'b11100, 5'b11101, 5'b11100, 5'b11100,
            5'b11010, 5'b11100, 5'b11101, 5'b10100, 5'b11100, 5'b11100, 5'b11100,
            5'b11100, 5'b11010, 5'b01010, 5'b01011, 5'b00001, 5'b00001, 5'b00000};
    rst = 1'b1; frame_start = 1'b0; w_req = 1'b0; r_req = 1'b0;
    w_addr = '0; w_wdata = '0; r_addr = '0;
    m_burst = 0; m_fill = 0; m_cen = 1'b1; m_wen = 1'b1; m_addr = '0; m_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_cen", int'(obs_cen), 1);
      chk("idle_rvalid", int'(obs_rv), 0);
      chk("idle_fill", obs_fill, 0);
    end

    // Fill past one frame to reach saturation
    for (int i = 0; i < FW + 3; i++) begin
      w_req = 1'b1; w_addr = AW'(i); w_wdata = DW'(i) ^ 8'h3C;
      cycle();
    end
    w_req = 1'b0;
    cycle();
    chk("fill_saturated", obs_fill, FW);

    // frame_start with a write at saturation, then sequential load while reader waits on addr 150
    frame_start = 1'b1; w_req = 1'b1; w_addr = '0; w_wdata = 8'h11;
    r_req = 1'b1; r_addr = AW'(150);
    nw = 0; first_fill = -1; got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      frame_start = 1'b0;
      if (c == 1) chk("fill_after_frame_start", obs_fill, 1);
      if (obs_wg) nw++;
      if (obs_rg) begin
        first_fill = obs_fill;
        got = 1'b1;
      end
      w_req = (nw < 151);
      w_addr = AW'(nw);
      w_wdata = DW'(nw) + 8'h11;
      r_req = !got;
      if (got) break;
    end
    w_req = 1'b0; r_req = 1'b0;
    chk("guard_read_granted", int'(got), 1);
    chk("guard_first_fill", first_fill, EXP_FIRST_FILL);
    nrv = 0; cap = -1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (obs_rv) begin
        nrv++;
        cap = int'(obs_rdata);
      end
    end
    chk("guard_rvalid_count", nrv, 1);
    chk("guard_rdata", cap, EXP_GUARD_DATA);

    for (int i = 0; i < 21; i++) begin
      w_req = tbl[i].w; w_addr = AW'(900 + i); w_wdata = DW'(i);
      r_req = tbl[i].r; r_addr = AW'(20 + i);
      cycle();
      chk($sformatf("tbl%0d_w_gnt", i), int'(obs_wg), int'(tbl[i].wg));
      chk($sformatf("tbl%0d_r_gnt", i), int'(obs_rg), int'(tbl[i].rg));
      chk($sformatf("tbl%0d_r_rvalid", i), int'(obs_rv), int'(tbl[i].rv));
    end
    w_req = 1'b0; r_req = 1'b0;

    w_req = 1'b1; w_addr = AW'(5); w_wdata = 8'hA7;
    cycle();
    w_req = 1'b0; r_req = 1'b1; r_addr = AW'(5);
    cycle();
    chk("single_r_gnt", int'(obs_rg), 1);
    r_req = 1'b0;
    cycle();
    chk("single_cen", int'(obs_cen), 0);
    chk("single_wen", int'(obs_wen), 1);
    chk("single_addr", int'(obs_addr), 5);
    cycle();
    chk("single_rvalid", int'(obs_rv), 1);
    chk("single_rdata", int'(obs_rdata), 8'hA7);

    r_req = 1'b1; r_addr = AW'(5);
    cycle();
    chk("rst_pre_r_gnt", int'(obs_rg), 1);
    r_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    nrv = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (c == 0) chk("rst_cen_idle", int'(obs_cen), 1);
      if (obs_rv) nrv++;
    end
    chk("rst_dropped_rvalid", nrv, 0);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      frame_start = ($urandom_range(0, 49) == 0);
      w_req = ($urandom_range(0, 2) != 0);
      r_req = ($urandom_range(0, 3) != 0);
      w_addr = AW'($urandom_range(0, 63));
      r_addr = AW'($urandom_range(0, 63));
      w_wdata = DW'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
